vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator; drives the vga_if_tim bundle (vcount/hcount/vsync/hsync/vblnk/hblnk).
//  Geometry, sync polarity and counter width are generics, so one block covers every mode the board supports.
//  Adds a pixel clock-enable and line/frame start strobes that the fixed 800x600 timing path lacks.
//  Sits at the head of the video pipeline; every draw stage consumes its outputs.
// PARAMETERS
//  CNT_W     11    width of hcount/vcount; H_TOTAL-1 and V_TOTAL-1 must fit (elaboration $error otherwise)
//  H_ACTIVE  800   visible pixels per line
//  H_FP      40    horizontal front porch (pixels)
//  H_SYNC    128   hsync pulse width (pixels)
//  H_BP      88    horizontal back porch (pixels); H_TOTAL = sum of the four = 1056
//  V_ACTIVE  600   visible lines per frame
//  V_FP      1     vertical front porch (lines)
//  V_SYNC    4     vsync pulse width (lines)
//  V_BP      23    vertical back porch (lines); V_TOTAL = 628
//  H_POL     1     hsync active level (1 = active-high)
//  V_POL     1     vsync active level
// PORTS
//  clk          in   1      pixel-domain clock
//  rst          in   1      synchronous, active-high reset
//  ce           in   1      pixel advance enable; counters step only when 1
//  hcount       out  CNT_W  horizontal position 0..H_TOTAL-1
//  vcount       out  CNT_W  vertical position 0..V_TOTAL-1
//  hblnk        out  1      1 when hcount >= H_ACTIVE
//  vblnk        out  1      1 when vcount >= V_ACTIVE
//  hsync        out  1      H_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~H_POL
//  vsync        out  1      V_POL when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, else ~V_POL
//  line_start   out  1      one-cycle strobe: outputs have just entered hcount==0
//  frame_start  out  1      one-cycle strobe: outputs have just entered hcount==0 && vcount==0
// BEHAVIOUR
//  - All outputs registered. Flags are decoded from the next count, so in every cycle each flag matches the count shown in that same cycle. No skew between count and flags.
//  - Reset (rst=1 at posedge): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~H_POL, vsync=~V_POL, line_start=0, frame_start=0.
//  - First cycle after rst deasserts: line_start=1 and frame_start=1, regardless of ce. Position (0,0) is announced once.
//  - ce=1: hcount <= (hcount==H_TOTAL-1) ? 0 : hcount+1.
//      On hcount wrap: vcount <= (vcount==V_TOTAL-1) ? 0 : vcount+1. Otherwise vcount holds.
//  - ce=0: counts and level flags hold; line_start and frame_start forced to 0.
//  - Strobes: line_start=1 only in the cycle after a ce that wrapped hcount. frame_start additionally requires that vcount wrapped.
//  - Counting is modulo arithmetic in CNT_W bits. Counts never exceed TOTAL-1, so no overflow path exists.
//  - rst mid-frame takes priority over ce and returns every output to its reset value in the next cycle.
//  - Sync windows with zero porch: H_FP=0 places hsync immediately at hcount=H_ACTIVE (the same applies to V_FP and vsync).
// TESTING
//  1 rst 3 cycles, ce=1 -> during rst: all counts 0, hsync=vsync=0 (default POL). First cycle after: frame_start=line_start=1.
//  2 Default params, ce=1 -> hblnk rises at hcount 800; hsync high for hcount 840..967; hcount 1055->0 with line_start=1, vcount+1.
//  3 Run to vcount 627, hcount 1055 -> next cycle (0,0) with frame_start=1. vsync high only for vcount 601..604.
//  4 ce toggling 1,0,0,1 at hcount 1055 -> outputs hold through the ce=0 cycles with no strobes; line_start fires once, after the final ce=1.
//  5 rst asserted at (hcount 500, vcount 300) -> next cycle all outputs at reset values. Restart produces an identical frame.
//  6 Tiny mode H=4/1/2/1, V=3/1/1/1, H_POL=V_POL=0 -> exhaustive compare of 2 full frames against a reference model; hsync=0 only at hcount 5,6.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Produces registered horizontal/vertical counts, blanking and sync flags,
// plus line/frame start strobes. Flags are decoded from the next count so
// every output in a given cycle describes the same raster position.
module vga_timing_gen #(
  parameter int CNT_W    = 11,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hblnk,
  output logic             vblnk,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Both counters must be able to hold their last position.
  if ((H_TOTAL - 1) >= (64'd1 << CNT_W) || (V_TOTAL - 1) >= (64'd1 << CNT_W)) begin : g_width_check
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end

  // ST_LAUNCH announces position (0,0) once after reset before counting starts.
  typedef enum logic {
    ST_LAUNCH,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;

  // Next position, strobes and flags decoded from the next position.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    unique case (state_q)
      ST_LAUNCH: begin
        state_d = ST_RUN;
        h_d     = '0;
        v_d     = '0;
        ls_d    = 1'b1;
        fs_d    = 1'b1;
      end
      ST_RUN: begin
        if (ce) begin
          if (h_q == H_LAST) begin
            h_d  = '0;
            ls_d = 1'b1;
            if (v_q == V_LAST) begin
              v_d  = '0;
              fs_d = 1'b1;
            end else begin
              v_d = v_q + CNT_W'(1);
            end
          end else begin
            h_d = h_q + CNT_W'(1);
          end
        end
      end
    endcase
    hblnk_d = (32'(h_d) >= H_ACTIVE);
    vblnk_d = (32'(v_d) >= V_ACTIVE);
    hsync_d = (32'(h_d) >= HS_BEG && 32'(h_d) < HS_END) ? H_POL : ~H_POL;
    vsync_d = (32'(v_d) >= VS_BEG && 32'(v_d) < VS_END) ? V_POL : ~V_POL;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LAUNCH;
      h_q     <= '0;
      v_q     <= '0;
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hblnk_q <= hblnk_d;
      vblnk_q <= vblnk_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: default 800x600 mode, a zero-porch
// active-high mode and a tiny active-low mode, all sharing clk/rst/ce.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  always #5 clk = ~clk;

  // default mode
  logic [10:0] d_h, d_v;
  logic d_hb, d_vb, d_hs, d_vs, d_ls, d_fs;
  // medium mode, zero front porches, active-high sync
  logic [3:0] m_h, m_v;
  logic m_hb, m_vb, m_hs, m_vs, m_ls, m_fs;
  // tiny mode, active-low sync, counters exactly fill CNT_W
  logic [2:0] t_h, t_v;
  logic t_hb, t_vb, t_hs, t_vs, t_ls, t_fs;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .ce(ce), .hcount(d_h), .vcount(d_v),
    .hblnk(d_hb), .vblnk(d_vb), .hsync(d_hs), .vsync(d_vs),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .CNT_W(4), .H_ACTIVE(8), .H_FP(0), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6), .V_FP(0), .V_SYNC(2), .V_BP(2), .H_POL(1'b1), .V_POL(1'b1)
  ) dut_m (
    .clk(clk), .rst(rst), .ce(ce), .hcount(m_h), .vcount(m_v),
    .hblnk(m_hb), .vblnk(m_vb), .hsync(m_hs), .vsync(m_vs),
    .line_start(m_ls), .frame_start(m_fs)
  );

  vga_timing_gen #(
    .CNT_W(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0)
  ) dut_t (
    .clk(clk), .rst(rst), .ce(ce), .hcount(t_h), .vcount(t_v),
    .hblnk(t_hb), .vblnk(t_vb), .hsync(t_hs), .vsync(t_vs),
    .line_start(t_ls), .frame_start(t_fs)
  );

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } geo_t;

  typedef struct {
    bit started;
    int h, v;
    bit hb, vb, hs, vs, ls, fs;
  } mst_t;

  typedef struct {
    mst_t d, m, t;
  } exp_t;

  typedef struct {
    bit r, c;
    int h, v;
    bit hs, vs, ls, fs;
  } vec_t;

  localparam geo_t GD = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  localparam geo_t GM = '{8, 0, 3, 5, 6, 0, 2, 2, 1'b1, 1'b1};
  localparam geo_t GT = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  mst_t md, mm, mt;
  logic [63:0] rec[96];

  // Reference raster model: one clock step of the timing behaviour.
  function automatic mst_t mstep(mst_t s, geo_t g, bit r, bit c);
    mst_t n = s;
    int ht = g.ha + g.hf + g.hs + g.hb;
    int vt = g.va + g.vf + g.vs + g.vb;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (r) begin
      n.started = 1'b0; n.h = 0; n.v = 0;
    end else if (!s.started) begin
      n.started = 1'b1; n.h = 0; n.v = 0; n.ls = 1'b1; n.fs = 1'b1;
    end else if (c) begin
      if (s.h == ht - 1) begin
        n.h = 0;
        n.ls = 1'b1;
        if (s.v == vt - 1) begin
          n.v = 0;
          n.fs = 1'b1;
        end else begin
          n.v = s.v + 1;
        end
      end else begin
        n.h = s.h + 1;
      end
    end
    n.hb = (n.h >= g.ha);
    n.vb = (n.v >= g.va);
    n.hs = (n.h >= g.ha + g.hf && n.h < g.ha + g.hf + g.hs) ? g.hp : !g.hp;
    n.vs = (n.v >= g.va + g.vf && n.v < g.va + g.vf + g.vs) ? g.vp : !g.vp;
    return n;
  endfunction

  function automatic logic [63:0] pk(int h, int v, bit hb, bit vb, bit hs, bit vs, bit ls, bit fs);
    return {26'd0, 16'(h), 16'(v), hb, vb, hs, vs, ls, fs};
  endfunction

  function automatic logic [63:0] pkm(mst_t s);
    return pk(s.h, s.v, s.hb, s.vb, s.hs, s.vs, s.ls, s.fs);
  endfunction

  function automatic logic [63:0] pk_d();
    return pk(int'(d_h), int'(d_v), d_hb, d_vb, d_hs, d_vs, d_ls, d_fs);
  endfunction

  function automatic logic [63:0] pk_m();
    return pk(int'(m_h), int'(m_v), m_hb, m_vb, m_hs, m_vs, m_ls, m_fs);
  endfunction

  function automatic logic [63:0] pk_t();
    return pk(int'(t_h), int'(t_v), t_hb, t_vb, t_hs, t_vs, t_ls, t_fs);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: drive inputs, push model expectations, sample after the edge.
  task automatic cyc(input bit r, input bit c);
    exp_t e;
    @(negedge clk);
    rst = r;
    ce  = c;
    md = mstep(md, GD, r, c);
    mm = mstep(mm, GM, r, c);
    mt = mstep(mt, GT, r, c);
    exp_q.push_back('{md, mm, mt});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("sb_def", pk_d(), pkm(e.d));
      chk("sb_med", pk_m(), pkm(e.m));
      chk("sb_tiny", pk_t(), pkm(e.t));
    end
    chk("tiny_hsync_win", 64'(t_hs), 64'(t_h != 3'd5 && t_h != 3'd6));
    chk("tiny_vsync_win", 64'(t_vs), 64'(t_v != 3'd4));
  endtask

  vec_t tbl[12];

  initial begin
    int first_hb, hs_first, hs_last, hs_cnt, ls_n, ls_v, ls_prev, prev_h, n;
    md = '{default: 0};
    mm = '{default: 0};
    mt = '{default: 0};

    // reset, launch strobe, ce hold and reset-then-launch with ce low
    tbl[0]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].c);
      chk($sformatf("tbl[%0d]", i), pk_d(),
          pk(tbl[i].h, tbl[i].v, 1'b0, 1'b0, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs));
    end

    // one full default line from a fresh reset
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("launch_strobes", 64'({d_ls, d_fs}), 64'd3);
    rec[0] = pk_t();
    first_hb = -1; hs_first = -1; hs_last = -1; hs_cnt = 0;
    ls_n = 0; ls_v = -1; ls_prev = -1; prev_h = int'(d_h);
    for (int i = 1; i < 1200; i++) begin
      cyc(1'b0, 1'b1);
      if (i < 96) rec[i] = pk_t();
      if (d_hb && first_hb < 0) first_hb = int'(d_h);
      if (d_hs) begin
        if (hs_first < 0) hs_first = int'(d_h);
        hs_last = int'(d_h);
        hs_cnt++;
      end
      if (d_ls) begin
        ls_n++;
        ls_v = int'(d_v);
        ls_prev = prev_h;
        chk("ls_at_h0", 64'(d_h), 64'd0);
      end
      prev_h = int'(d_h);
    end
    chk("hblnk_rise", 64'(first_hb), 64'd800);
    chk("hsync_first", 64'(hs_first), 64'd840);
    chk("hsync_last", 64'(hs_last), 64'd967);
    chk("hsync_width", 64'(hs_cnt), 64'd128);
    chk("ls_count", 64'(ls_n), 64'd1);
    chk("ls_vcount", 64'(ls_v), 64'd1);
    chk("ls_prev_h", 64'(ls_prev), 64'd1055);
    chk("hblnk_fall", 64'(d_hb), 64'd0);

    // ce 1,0,0,1 around the end of a line
    n = 0;
    while (d_h != 11'd1055 && n < 1100) begin
      cyc(1'b0, 1'b1);
      n++;
    end
    chk("reach_1055", 64'(d_h), 64'd1055);
    cyc(1'b0, 1'b0);
    chk("hold_1", pk_d(), pk(1055, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0);
    chk("hold_2", pk_d(), pk(1055, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1);
    chk("wrap_after_hold", pk_d(), pk(0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 1'b1);
    chk("post_wrap", pk_d(), pk(1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // mid-frame reset, then the tiny raster must replay identically
    n = 0;
    while (d_h != 11'd500 && n < 600) begin
      cyc(1'b0, 1'b1);
      n++;
    end
    chk("reach_500", 64'(d_h), 64'd500);
    cyc(1'b1, 1'b1);
    chk("midrst_def", pk_d(), pk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("midrst_tiny", pk_t(), pk(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    chk("midrst_med", pk_m(), pk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1);
    chk("relaunch_strobes", 64'({d_ls, d_fs}), 64'd3);
    chk("replay[0]", pk_t(), rec[0]);
    for (int i = 1; i < 96; i++) begin
      cyc(1'b0, 1'b1);
      chk($sformatf("replay[%0d]", i), pk_t(), rec[i]);
    end

    // a few more frames of the small modes with random ce
    for (int i = 0; i < 400; i++) cyc(1'b0, 1'($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
